// File: rtl/addsub_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : addsub_pkg
// Purpose  : Shared opcode encoding, flag bundle and limits for addsub_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Bit 0 selects subtract, bit 1 selects saturation.
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_SADD = 2'b10,
        OP_SSUB = 2'b11
    } op_t;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic sat;
    } flags_t;

    localparam int STAGES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/addsub_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : addsub_pipe_if
// Purpose   : Operand/result valid-ready bundle for addsub_pipe.
// Revision  : 1.0 - initial release
// ============================================================================
interface addsub_pipe_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             sat;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, ovf, sat
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, ovf, sat
    );

endinterface
`default_nettype wire

// File: rtl/addsub_pipe_core.sv
`default_nettype none
// ============================================================================
// Module   : addsub_core
// Purpose  : Combinational add/subtract with carry/borrow and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_core #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_sub,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_carry,
    output logic                  o_ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum   = w_full[WIDTH-1:0];
    // For a+~b+1 the carry-out is the inverse of the borrow.
    assign o_carry = w_full[WIDTH] ^ i_sub;

    generate
        if (SIGNED != 0) begin : g_signed
            assign o_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                           (w_full[WIDTH-1] != i_a[WIDTH-1]);
        end else begin : g_unsigned
            assign o_ovf = o_carry;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe
// Purpose  : Pipelined add/sub (optional saturation) with valid/ready flow.
//            Simulation checks enabled by ADDSUB_PIPE_XCHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int SIGNED = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    addsub_pipe_if.slave bus
);

    localparam int c_last = STAGES - 1;

    generate
        if (STAGES < 1 || STAGES > STAGES_MAX || WIDTH < 2) begin : g_param_err
            $error("addsub_pipe: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
        end
    endgenerate

    logic             w_adv;
    logic [WIDTH-1:0] w_core_sum;
    logic             w_core_carry;
    logic             w_core_ovf;
    logic             w_sat_en;
    logic [WIDTH-1:0] w_sat_val;

    logic             r_v         [STAGES];
    logic [WIDTH-1:0] r_sum       [STAGES];
    op_t              r_op        [STAGES];
    flags_t           r_flags     [STAGES];

    logic             w_src_v     [STAGES];
    logic [WIDTH-1:0] w_src_sum   [STAGES];
    op_t              w_src_op    [STAGES];
    flags_t           w_src_flags [STAGES];
    logic [WIDTH-1:0] w_nxt_sum   [STAGES];
    flags_t           w_nxt_flags [STAGES];

    assign w_adv        = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_adv && !rst;

    addsub_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .i_a     (bus.a),
        .i_b     (bus.b),
        .i_sub   (bus.op[0]),
        .o_sum   (w_core_sum),
        .o_carry (w_core_carry),
        .o_ovf   (w_core_ovf)
    );

    // Clamp target; signed direction follows the wrapped MSB (it has the wrong sign).
    generate
        if (SIGNED != 0) begin : g_sat_signed
            assign w_sat_val = w_src_sum[c_last][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                          : {1'b1, {(WIDTH-1){1'b0}}};
        end else begin : g_sat_unsigned
            assign w_sat_val = w_src_op[c_last][0] ? '0 : '1;
        end
    endgenerate

    assign w_sat_en = w_src_op[c_last][1] && w_src_flags[c_last].ovf;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_src_v[k]     = bus.in_valid;
                assign w_src_sum[k]   = w_core_sum;
                assign w_src_op[k]    = bus.op;
                assign w_src_flags[k] = flags_t'({w_core_carry, w_core_ovf, 1'b0});
            end else begin : g_delay
                assign w_src_v[k]     = r_v[k-1];
                assign w_src_sum[k]   = r_sum[k-1];
                assign w_src_op[k]    = r_op[k-1];
                assign w_src_flags[k] = r_flags[k-1];
            end

            if (k == STAGES - 1) begin : g_final
                assign w_nxt_sum[k]   = w_sat_en ? w_sat_val : w_src_sum[k];
                assign w_nxt_flags[k] = flags_t'({w_src_flags[k].carry,
                                                  w_src_flags[k].ovf, w_sat_en});
            end else begin : g_pass
                assign w_nxt_sum[k]   = w_src_sum[k];
                assign w_nxt_flags[k] = w_src_flags[k];
            end
        end
    endgenerate

    // Data only loads behind a valid token, so bubbles leave registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]     <= 1'b0;
                r_sum[k]   <= '0;
                r_op[k]    <= OP_ADD;
                r_flags[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_src_v[k];
                if (w_src_v[k]) begin
                    r_sum[k]   <= w_nxt_sum[k];
                    r_op[k]    <= w_src_op[k];
                    r_flags[k] <= w_nxt_flags[k];
                end
            end
        end
    end

    assign bus.out_valid = r_v[c_last];
    assign bus.result    = r_sum[c_last];
    assign bus.carry     = r_flags[c_last].carry;
    assign bus.ovf       = r_flags[c_last].ovf;
    assign bus.sat       = r_flags[c_last].sat;

`ifdef ADDSUB_PIPE_XCHECK_EN
    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready && $isunknown({bus.op, bus.a, bus.b}))
            $error("addsub_pipe: unknown operands accepted at %t", $realtime);
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=>
            $stable({bus.result, bus.carry, bus.ovf, bus.sat}));

    a_sat_implies_ovf: assert property (@(posedge clk) disable iff (rst)
        bus.sat |-> bus.ovf);
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_pipe
// Purpose  : Self-checking bench for addsub_pipe over four WIDTH=8 configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int c_n = 4;
    localparam int c_st [c_n] = '{2, 2, 1, 4};
    localparam int c_sg [c_n] = '{0, 1, 1, 0};

    typedef struct packed {
        logic [7:0] res;
        logic       cy;
        logic       ovf;
        logic       sat;
    } exp_t;

    typedef struct {
        op_t        op;
        logic [7:0] a;
        logic [7:0] b;
        int         dut;
        exp_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    op_t        op = OP_ADD;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_ready = 1'b1;

    logic       w_ir  [c_n];
    logic       w_ov  [c_n];
    logic [7:0] w_res [c_n];
    logic       w_cy  [c_n];
    logic       w_ovf [c_n];
    logic       w_sat [c_n];

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < c_n; i++) begin : g_dut
            addsub_pipe_if #(.WIDTH(8)) u_bus ();
            assign u_bus.in_valid  = in_valid;
            assign u_bus.op        = op;
            assign u_bus.a         = a;
            assign u_bus.b         = b;
            assign u_bus.out_ready = out_ready;
            assign w_ir[i]  = u_bus.in_ready;
            assign w_ov[i]  = u_bus.out_valid;
            assign w_res[i] = u_bus.result;
            assign w_cy[i]  = u_bus.carry;
            assign w_ovf[i] = u_bus.ovf;
            assign w_sat[i] = u_bus.sat;

            addsub_pipe #(
                .WIDTH  (8),
                .STAGES (c_st[i]),
                .SIGNED (c_sg[i])
            ) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (u_bus.slave)
            );
        end
    endgenerate

    int   n_pass = 0;
    int   n_total = 0;
    exp_t fifo  [c_n][64];
    int   wr    [c_n] = '{0, 0, 0, 0};
    int   rd    [c_n] = '{0, 0, 0, 0};
    int   n_out [c_n] = '{0, 0, 0, 0};
    bit   hold  [c_n] = '{0, 0, 0, 0};
    exp_t held  [c_n];
    bit   acc0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: true mathematical result, then range test and clamp.
    function automatic exp_t model(input op_t o, input logic [7:0] x, input logic [7:0] y, input bit sgn);
        exp_t e;
        int   ux = int'(x);
        int   uy = int'(y);
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   t, hi, lo;
        bit   is_sub = (o == OP_SUB) || (o == OP_SSUB);
        bit   is_sat = (o == OP_SADD) || (o == OP_SSUB);
        e.cy = is_sub ? (ux < uy) : ((ux + uy) > 255);
        if (sgn) begin
            t  = is_sub ? sx - sy : sx + sy;
            hi = 127;
            lo = -128;
        end else begin
            t  = is_sub ? ux - uy : ux + uy;
            hi = 255;
            lo = 0;
        end
        e.ovf = (t > hi) || (t < lo);
        e.sat = is_sat && e.ovf;
        if (e.sat) t = (t > hi) ? hi : lo;
        e.res = t[7:0];
        return e;
    endfunction

    task automatic monitor_all();
        exp_t got;
        for (int i = 0; i < c_n; i++) begin
            got = {w_res[i], w_cy[i], w_ovf[i], w_sat[i]};
            if (rst) begin
                check($sformatf("d%0d_in_ready_rst", i), 32'(w_ir[i]), 32'(0));
                rd[i]   = wr[i];
                hold[i] = 1'b0;
            end else begin
                check($sformatf("d%0d_in_ready", i), 32'(w_ir[i]), 32'(!w_ov[i] || out_ready));
                if (hold[i])
                    check($sformatf("d%0d_hold", i), {w_ov[i], got}, {1'b1, held[i]});
                if (w_ov[i] && out_ready) begin
                    n_out[i]++;
                    check($sformatf("d%0d_expected_output", i), 32'(wr[i] != rd[i]), 32'(1));
                    if (wr[i] != rd[i]) begin
                        check($sformatf("d%0d_out%0d", i, n_out[i]), 32'(got), 32'(fifo[i][rd[i] % 64]));
                        rd[i]++;
                    end
                end
                if (in_valid && w_ir[i]) begin
                    fifo[i][wr[i] % 64] = model(op, a, b, c_sg[i] != 0);
                    wr[i]++;
                end
                hold[i] = w_ov[i] && !out_ready;
                held[i] = got;
            end
        end
        acc0 = !rst && in_valid && w_ir[0];
    endtask

    task automatic step();
        @(negedge clk);
        monitor_all();
        @(posedge clk);
        #1;
    endtask

    vec_t vec [12];
    int   lat;
    bit   seen;
    exp_t snap;
    int   out0_base;
    int   stall_acc;

    initial begin
        vec[0]  = '{OP_ADD,  8'hF0, 8'h20, 0, exp_t'({8'h10, 1'b1, 1'b1, 1'b0})};
        vec[1]  = '{OP_SADD, 8'hF0, 8'h20, 0, exp_t'({8'hFF, 1'b1, 1'b1, 1'b1})};
        vec[2]  = '{OP_SSUB, 8'h10, 8'h20, 0, exp_t'({8'h00, 1'b1, 1'b1, 1'b1})};
        vec[3]  = '{OP_SUB,  8'h10, 8'h20, 0, exp_t'({8'hF0, 1'b1, 1'b1, 1'b0})};
        vec[4]  = '{OP_SADD, 8'h70, 8'h20, 1, exp_t'({8'h7F, 1'b0, 1'b1, 1'b1})};
        vec[5]  = '{OP_SSUB, 8'h80, 8'h01, 1, exp_t'({8'h80, 1'b0, 1'b1, 1'b1})};
        vec[6]  = '{OP_ADD,  8'h70, 8'h20, 1, exp_t'({8'h90, 1'b0, 1'b1, 1'b0})};
        vec[7]  = '{OP_ADD,  8'h01, 8'h02, 0, exp_t'({8'h03, 1'b0, 1'b0, 1'b0})};
        vec[8]  = '{OP_SUB,  8'h05, 8'h07, 1, exp_t'({8'hFE, 1'b1, 1'b0, 1'b0})};
        vec[9]  = '{OP_SADD, 8'hF0, 8'hF0, 1, exp_t'({8'hE0, 1'b1, 1'b0, 1'b0})};
        vec[10] = '{OP_SADD, 8'h7F, 8'h80, 0, exp_t'({8'hFF, 1'b0, 1'b0, 1'b0})};
        vec[11] = '{OP_SSUB, 8'h7F, 8'hFF, 1, exp_t'({8'h7F, 1'b1, 1'b1, 1'b1})};

        // Reset state, during and on the first cycle after reset.
        @(posedge clk);
        #1;
        step();
        @(negedge clk);
        for (int i = 0; i < c_n; i++)
            check($sformatf("d%0d_reset_state", i),
                  {w_ov[i], w_res[i], w_cy[i], w_ovf[i], w_sat[i]}, 32'(0));
        monitor_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < c_n; i++)
            check($sformatf("d%0d_valid_after_reset", i), 32'(w_ov[i]), 32'(0));
        monitor_all();
        @(posedge clk);
        #1;

        // Directed vectors with latency measurement.
        for (int t = 0; t < 12; t++) begin
            in_valid = 1'b1;
            op = vec[t].op;
            a  = vec[t].a;
            b  = vec[t].b;
            step();
            in_valid = 1'b0;
            lat  = 0;
            seen = 1'b0;
            snap = '0;
            while (!seen && lat < 8) begin
                @(negedge clk);
                lat++;
                if (w_ov[vec[t].dut]) begin
                    seen = 1'b1;
                    snap = {w_res[vec[t].dut], w_cy[vec[t].dut], w_ovf[vec[t].dut], w_sat[vec[t].dut]};
                end
                monitor_all();
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_latency", t), 32'(lat), 32'(2));
            check($sformatf("vec%0d_result", t), 32'(snap), 32'(vec[t].exp));
            repeat (4) step();
        end

        // Six back-to-back ops with a three-cycle output stall.
        out0_base = n_out[0];
        stall_acc = 0;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 6 && cyc < 40) begin
                in_valid  = 1'b1;
                op        = op_t'(k % 4);
                a         = 8'(8'h30 * k + 8'h11);
                b         = 8'(8'h25 + k);
                out_ready = !(cyc >= 4 && cyc < 7);
                step();
                if (acc0) begin
                    k++;
                    if (!out_ready) stall_acc++;
                end
                cyc++;
            end
            check("bp_all_accepted", 32'(k), 32'(6));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("bp_no_accept_in_stall", 32'(stall_acc), 32'(0));
        check("bp_outputs", 32'(n_out[0] - out0_base), 32'(6));

        // Reset with two ops in flight; nothing stale may emerge afterwards.
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            op = OP_ADD;
            a  = 8'(8'h40 + k);
            b  = 8'h01;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < c_n; i++)
            check($sformatf("d%0d_flush_valid", i), 32'(w_ov[i]), 32'(0));
        monitor_all();
        @(posedge clk);
        #1;
        repeat (8) step();

        // Randomized traffic with random backpressure and occasional reset.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = op_t'($urandom_range(0, 3));
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < c_n; i++)
            check($sformatf("d%0d_drained", i), 32'(wr[i] - rd[i]), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
